// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared definitions for the rv64IM pipeline hazard/sequencing controller:
//   controller state encoding, trap cause codes for dmem access faults, and
//   the helper that aligns mtvec into a fetch address.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PCTL_RUN   = 2'd0,
    PCTL_DWAIT = 2'd1,
    PCTL_TRAP  = 2'd2
  } pctl_state_e;

  localparam logic [63:0] CAUSE_LOAD_ACCESS_FAULT  = 64'd5;
  localparam logic [63:0] CAUSE_STORE_ACCESS_FAULT = 64'd7;

  // mtvec low bits carry the vector mode; the fetch target is always word aligned.
  localparam logic [63:0] TRAP_VEC_MASK = ~64'd3;

  function automatic logic [63:0] align_trap_vec(input logic [63:0] vec);
    return vec & TRAP_VEC_MASK;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// pipeline_ctrl_hazard_detect
//   Combinational load-use detector: flags when the instruction in ID reads
//   a register that a load currently in EX will write. x0 never hazards.
// Ports
//   id_rs1, id_rs2           in  5  source registers of the ID instruction
//   id_rs1_used, id_rs2_used in  1  source actually read
//   ex_load                  in  1  instruction in EX is a load
//   ex_rd                    in  5  destination of the EX instruction
//   load_use                 out 1  hazard present this cycle
module pipeline_ctrl_hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  // Compare both used sources against the load destination.
  always_comb begin
    load_use = 1'b0;
    if (ex_load && (ex_rd != 5'd0)) begin
      load_use = (id_rs1_used && (id_rs1 == ex_rd)) ||
                 (id_rs2_used && (id_rs2 == ex_rd));
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central hazard/sequencing controller of the 5-stage rv64IM pipeline.
//   Generates stall/flush for if_id, id_ex, ex_mem, a bubble for mem_wb, the
//   dmem kill, PC redirects (ID branch, trap vector, mret) and trap commits.
//   Fixed priority: WB exception/mret > dmem wait/timeout > MDU busy >
//   load-use > ID redirect. A dmem access that waits DMEM_TIMEOUT cycles is
//   killed and raises a load/store access fault.
//   Outputs are combinational from state and inputs; all forced to 0 while
//   reset is asserted.
// Ports
//   clock, reset (async, active low)
//   id_*      ID source regs/usage, ID redirect request and target
//   ex_*      EX load/rd, multi-cycle MDU busy
//   mem_*     MEM load/store/pc; dmem_ready completes the MEM access
//   wb_*      WB exception/mret, faulting pc and cause
//   mtvec, mepc  CSR values
//   stall/flush/bubble/kill controls, redirect_valid/pc, trap_commit/pc/cause
//   perf_stall_cnt, perf_flush_cnt  performance counters
// Configuration
//   PIPELINE_CTRL_PERF_EN: when defined, perf counters are built (64-bit,
//   wrapping); otherwise both counter ports are tied to 0.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        id_redirect,
  input  logic [63:0] id_target,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mdu_busy,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [63:0] mem_pc,
  input  logic        dmem_ready,
  input  logic        wb_exception,
  input  logic        wb_mret,
  input  logic [63:0] wb_pc,
  input  logic [63:0] wb_cause,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        ex_mem_flush,
  output logic        mem_wb_bubble,
  output logic        mem_kill,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        trap_commit,
  output logic [63:0] trap_pc,
  output logic [63:0] trap_cause,
  output logic [63:0] perf_stall_cnt,
  output logic [63:0] perf_flush_cnt
);

  pctl_state_e      state_r;
  pctl_state_e      state_next_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_next_s;
  logic             load_use_s;
  logic             mem_access_s;
  logic             timeout_s;

  pipeline_ctrl_hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_load     (ex_load),
    .ex_rd       (ex_rd),
    .load_use    (load_use_s)
  );

  assign mem_access_s = mem_load | mem_store;
  // This wait cycle is the last one allowed: the access is abandoned now.
  assign timeout_s    = (wait_cnt_r == CNT_W'(DMEM_TIMEOUT - 1));

  // State and dmem wait counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= PCTL_RUN;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Next-state and output decode with fixed hazard priority.
  always_comb begin
    pc_stall        = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_stall     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_stall    = 1'b0;
    ex_mem_flush    = 1'b0;
    mem_wb_bubble   = 1'b0;
    mem_kill        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    trap_commit     = 1'b0;
    trap_pc         = 64'd0;
    trap_cause      = 64'd0;
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;

    if (!reset) begin
      state_next_s    = PCTL_RUN;
      wait_cnt_next_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        PCTL_TRAP: begin
          // Pipe was already flushed when the trap committed; any WB event
          // seen now belongs to a squashed instruction.
          redirect_valid  = 1'b1;
          redirect_pc     = align_trap_vec(mtvec);
          if_id_flush     = 1'b1;
          id_ex_flush     = 1'b1;
          wait_cnt_next_s = {CNT_W{1'b0}};
          state_next_s    = PCTL_RUN;
        end
        PCTL_RUN, PCTL_DWAIT: begin
          if (wb_exception || wb_mret) begin
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            ex_mem_flush    = 1'b1;
            mem_wb_bubble   = 1'b1;
            mem_kill        = 1'b1;
            wait_cnt_next_s = {CNT_W{1'b0}};
            if (wb_exception) begin
              trap_commit  = 1'b1;
              trap_pc      = wb_pc;
              trap_cause   = wb_cause;
              state_next_s = PCTL_TRAP;
            end else begin
              redirect_valid = 1'b1;
              redirect_pc    = mepc;
              state_next_s   = PCTL_RUN;
            end
          end else if (mem_access_s && !dmem_ready) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            mem_wb_bubble = 1'b1;
            if (timeout_s) begin
              // ex_mem is flushed rather than held so it is never both.
              ex_mem_flush    = 1'b1;
              mem_kill        = 1'b1;
              trap_commit     = 1'b1;
              trap_pc         = mem_pc;
              trap_cause      = mem_store ? CAUSE_STORE_ACCESS_FAULT
                                          : CAUSE_LOAD_ACCESS_FAULT;
              wait_cnt_next_s = {CNT_W{1'b0}};
              state_next_s    = PCTL_TRAP;
            end else begin
              ex_mem_stall    = 1'b1;
              wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
              state_next_s    = PCTL_DWAIT;
            end
          end else begin
            wait_cnt_next_s = {CNT_W{1'b0}};
            state_next_s    = PCTL_RUN;
            if (ex_mdu_busy) begin
              pc_stall     = 1'b1;
              if_id_stall  = 1'b1;
              id_ex_stall  = 1'b1;
              ex_mem_flush = 1'b1;
            end else if (load_use_s) begin
              // The consumer stays in ID, so its branch decision is stale.
              pc_stall    = 1'b1;
              if_id_stall = 1'b1;
              id_ex_flush = 1'b1;
            end else if (id_redirect) begin
              redirect_valid = 1'b1;
              redirect_pc    = id_target;
              if_id_flush    = 1'b1;
            end else begin
              redirect_valid = 1'b0;
            end
          end
        end
        default: begin
          wait_cnt_next_s = {CNT_W{1'b0}};
          state_next_s    = PCTL_RUN;
        end
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [63:0] perf_stall_r;
  logic [63:0] perf_flush_r;
  logic        flush_any_s;

  assign flush_any_s = if_id_flush | id_ex_flush | ex_mem_flush;

  // Free-running stall/flush cycle counters, wrapping at 2^64.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_r <= 64'd0;
      perf_flush_r <= 64'd0;
    end else begin
      if (pc_stall) begin
        perf_stall_r <= perf_stall_r + 64'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
      if (flush_any_s) begin
        perf_flush_r <= perf_flush_r + 64'd1;
      end else begin
        perf_flush_r <= perf_flush_r;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_r;
  assign perf_flush_cnt = perf_flush_r;
`else
  assign perf_stall_cnt = 64'd0;
  assign perf_flush_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Self-checking bench for pipeline_ctrl: table vectors, hand sequences for
//   dmem wait/timeout, MDU stall and reset mid-wait, then random stimulus
//   against a behavioural model of the controller rules.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 64;

  // flag bit positions in the packed output flag vector
  localparam int B_PC_ST  = 10;
  localparam int B_IFI_ST = 9;
  localparam int B_IFI_FL = 8;
  localparam int B_IDE_ST = 7;
  localparam int B_IDE_FL = 6;
  localparam int B_EXM_ST = 5;
  localparam int B_EXM_FL = 4;
  localparam int B_BUBBLE = 3;
  localparam int B_KILL   = 2;
  localparam int B_RVALID = 1;
  localparam int B_TRAP   = 0;

  localparam logic [10:0] F_NONE     = 11'b00000000000;
  localparam logic [10:0] F_LOADUSE  = 11'b11001000000;
  localparam logic [10:0] F_REDIRECT = 11'b00100000010;
  localparam logic [10:0] F_MDU      = 11'b11010010000;
  localparam logic [10:0] F_DWAIT    = 11'b11010101000;
  localparam logic [10:0] F_TIMEOUT  = 11'b11010011101;
  localparam logic [10:0] F_TRAPST   = 11'b00101000010;
  localparam logic [10:0] F_EXC      = 11'b00101011101;
  localparam logic [10:0] F_MRET     = 11'b00101011110;

  typedef struct packed {
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        id_redirect;
    logic [63:0] id_target;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        ex_mdu_busy;
    logic        mem_load;
    logic        mem_store;
    logic [63:0] mem_pc;
    logic        dmem_ready;
    logic        wb_exception;
    logic        wb_mret;
    logic [63:0] wb_pc;
    logic [63:0] wb_cause;
    logic [63:0] mtvec;
    logic [63:0] mepc;
  } in_t;

  typedef struct packed {
    logic [10:0] flags;
    logic [63:0] rpc;
    logic [63:0] tpc;
    logic [63:0] tcause;
  } out_t;

  typedef struct {
    in_t         stim;
    logic [10:0] flags;
    logic [63:0] rpc;
    logic [63:0] tpc;
    logic [63:0] tcause;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, id_redirect, ex_load, ex_mdu_busy;
  logic        mem_load, mem_store, dmem_ready, wb_exception, wb_mret;
  logic [63:0] id_target, mem_pc, wb_pc, wb_cause, mtvec, mepc;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, ex_mem_flush, mem_wb_bubble, mem_kill;
  logic        redirect_valid, trap_commit;
  logic [63:0] redirect_pc, trap_pc, trap_cause, perf_stall_cnt, perf_flush_cnt;
  logic [10:0] act_flags;

  int          n_checks = 0;
  int          n_errors = 0;

  // behavioural model state
  bit          m_trap;
  int          m_wait;
  logic [63:0] m_perf_stall;
  logic [63:0] m_perf_flush;

  in_t         idle;
  logic [10:0] last_flags;
  logic [63:0] last_rpc, last_tpc, last_tcause;
  vec_t        vecs[12];

  always #5 clock = ~clock;

  assign act_flags = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                      ex_mem_stall, ex_mem_flush, mem_wb_bubble, mem_kill,
                      redirect_valid, trap_commit};

  pipeline_ctrl #(.DMEM_TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_redirect(id_redirect), .id_target(id_target),
    .ex_load(ex_load), .ex_rd(ex_rd), .ex_mdu_busy(ex_mdu_busy),
    .mem_load(mem_load), .mem_store(mem_store), .mem_pc(mem_pc), .dmem_ready(dmem_ready),
    .wb_exception(wb_exception), .wb_mret(wb_mret), .wb_pc(wb_pc), .wb_cause(wb_cause),
    .mtvec(mtvec), .mepc(mepc),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_kill(mem_kill),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_commit(trap_commit), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t i);
    id_rs1 = i.id_rs1; id_rs2 = i.id_rs2;
    id_rs1_used = i.id_rs1_used; id_rs2_used = i.id_rs2_used;
    id_redirect = i.id_redirect; id_target = i.id_target;
    ex_load = i.ex_load; ex_rd = i.ex_rd; ex_mdu_busy = i.ex_mdu_busy;
    mem_load = i.mem_load; mem_store = i.mem_store; mem_pc = i.mem_pc;
    dmem_ready = i.dmem_ready;
    wb_exception = i.wb_exception; wb_mret = i.wb_mret;
    wb_pc = i.wb_pc; wb_cause = i.wb_cause; mtvec = i.mtvec; mepc = i.mepc;
  endtask

  task automatic model_reset();
    m_trap = 1'b0;
    m_wait = 0;
    m_perf_stall = 64'd0;
    m_perf_flush = 64'd0;
  endtask

  // Expected controller response from the priority rules.
  function automatic out_t model_out(input in_t i);
    out_t o;
    bit   lu;
    o = '0;
    lu = i.ex_load && (i.ex_rd != 5'd0) &&
         ((i.id_rs1_used && (i.id_rs1 == i.ex_rd)) || (i.id_rs2_used && (i.id_rs2 == i.ex_rd)));
    if (m_trap) begin
      o.flags[B_RVALID] = 1'b1;
      o.rpc = i.mtvec - (i.mtvec % 64'd4);
      o.flags[B_IFI_FL] = 1'b1;
      o.flags[B_IDE_FL] = 1'b1;
    end else if (i.wb_exception || i.wb_mret) begin
      o.flags[B_IFI_FL] = 1'b1; o.flags[B_IDE_FL] = 1'b1; o.flags[B_EXM_FL] = 1'b1;
      o.flags[B_BUBBLE] = 1'b1; o.flags[B_KILL] = 1'b1;
      if (i.wb_exception) begin
        o.flags[B_TRAP] = 1'b1; o.tpc = i.wb_pc; o.tcause = i.wb_cause;
      end else begin
        o.flags[B_RVALID] = 1'b1; o.rpc = i.mepc;
      end
    end else if ((i.mem_load || i.mem_store) && !i.dmem_ready) begin
      o.flags[B_PC_ST] = 1'b1; o.flags[B_IFI_ST] = 1'b1; o.flags[B_IDE_ST] = 1'b1;
      o.flags[B_BUBBLE] = 1'b1;
      if (m_wait == TIMEOUT - 1) begin
        o.flags[B_EXM_FL] = 1'b1; o.flags[B_KILL] = 1'b1; o.flags[B_TRAP] = 1'b1;
        o.tpc = i.mem_pc;
        o.tcause = i.mem_store ? 64'd7 : 64'd5;
      end else begin
        o.flags[B_EXM_ST] = 1'b1;
      end
    end else if (i.ex_mdu_busy) begin
      o.flags[B_PC_ST] = 1'b1; o.flags[B_IFI_ST] = 1'b1; o.flags[B_IDE_ST] = 1'b1;
      o.flags[B_EXM_FL] = 1'b1;
    end else if (lu) begin
      o.flags[B_PC_ST] = 1'b1; o.flags[B_IFI_ST] = 1'b1; o.flags[B_IDE_FL] = 1'b1;
    end else if (i.id_redirect) begin
      o.flags[B_RVALID] = 1'b1; o.rpc = i.id_target; o.flags[B_IFI_FL] = 1'b1;
    end
    return o;
  endfunction

  task automatic model_update(input in_t i, input out_t o);
    if (o.flags[B_PC_ST]) m_perf_stall = m_perf_stall + 64'd1;
    if (o.flags[B_IFI_FL] || o.flags[B_IDE_FL] || o.flags[B_EXM_FL])
      m_perf_flush = m_perf_flush + 64'd1;
    if (m_trap) begin
      m_trap = 1'b0; m_wait = 0;
    end else if (i.wb_exception || i.wb_mret) begin
      m_trap = i.wb_exception; m_wait = 0;
    end else if ((i.mem_load || i.mem_store) && !i.dmem_ready) begin
      if (m_wait == TIMEOUT - 1) begin
        m_trap = 1'b1; m_wait = 0;
      end else begin
        m_wait = m_wait + 1;
      end
    end else begin
      m_wait = 0;
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, compare with model, advance.
  task automatic step(input in_t i, input string tag);
    out_t        e;
    logic [63:0] exp_ps, exp_pf;
    @(negedge clock);
    apply(i);
    #1;
    e = model_out(i);
`ifdef PIPELINE_CTRL_PERF_EN
    exp_ps = m_perf_stall; exp_pf = m_perf_flush;
`else
    exp_ps = 64'd0; exp_pf = 64'd0;
`endif
    last_flags = act_flags; last_rpc = redirect_pc;
    last_tpc = trap_pc; last_tcause = trap_cause;
    chk({tag, " flags"}, 64'(act_flags), 64'(e.flags));
    chk({tag, " redirect_pc"}, redirect_pc, e.rpc);
    chk({tag, " trap_pc"}, trap_pc, e.tpc);
    chk({tag, " trap_cause"}, trap_cause, e.tcause);
    chk({tag, " perf_stall"}, perf_stall_cnt, exp_ps);
    chk({tag, " perf_flush"}, perf_flush_cnt, exp_pf);
    @(posedge clock);
    model_update(i, e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    apply(idle);
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " flags"}, 64'(act_flags), 64'd0);
    chk({tag, " redirect_pc"}, redirect_pc, 64'd0);
    chk({tag, " trap_pc"}, trap_pc, 64'd0);
    chk({tag, " trap_cause"}, trap_cause, 64'd0);
    chk({tag, " perf_stall"}, perf_stall_cnt, 64'd0);
    chk({tag, " perf_flush"}, perf_flush_cnt, 64'd0);
  endtask

  initial begin
    in_t v;
    idle = '0;
    idle.dmem_ready = 1'b1;
    idle.id_target  = 64'h0000_0000_8000_0100;
    idle.mem_pc     = 64'h0000_0000_8000_2000;
    idle.wb_pc      = 64'h0000_0000_8000_3000;
    idle.wb_cause   = 64'd2;
    idle.mtvec      = 64'h0000_0000_8000_0007;
    idle.mepc       = 64'h0000_0000_8000_4000;
    apply(idle);
    model_reset();

    // reset state: outputs held at zero while reset is asserted
    #3;
    chk_all_zero("reset");

    // ---- table vectors, each from a fresh RUN state
    v = idle;                                               vecs[0]  = '{v, F_NONE, 64'd0, 64'd0, 64'd0};
    v = idle; v.ex_load = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_rs1_used = 1;
                                                            vecs[1]  = '{v, F_LOADUSE, 64'd0, 64'd0, 64'd0};
    v = idle; v.ex_load = 1; v.ex_rd = 0; v.id_rs1 = 0; v.id_rs1_used = 1;
                                                            vecs[2]  = '{v, F_NONE, 64'd0, 64'd0, 64'd0};
    v = idle; v.ex_load = 1; v.ex_rd = 9; v.id_rs2 = 9; v.id_rs2_used = 0;
                                                            vecs[3]  = '{v, F_NONE, 64'd0, 64'd0, 64'd0};
    v = idle; v.ex_load = 1; v.ex_rd = 9; v.id_rs2 = 9; v.id_rs2_used = 1;
                                                            vecs[4]  = '{v, F_LOADUSE, 64'd0, 64'd0, 64'd0};
    v = vecs[1].stim; v.id_redirect = 1;                    vecs[5]  = '{v, F_LOADUSE, 64'd0, 64'd0, 64'd0};
    v = idle; v.id_redirect = 1;                            vecs[6]  = '{v, F_REDIRECT, 64'h8000_0100, 64'd0, 64'd0};
    v = idle; v.ex_mdu_busy = 1; v.id_redirect = 1;         vecs[7]  = '{v, F_MDU, 64'd0, 64'd0, 64'd0};
    v = idle; v.mem_load = 1; v.dmem_ready = 0;             vecs[8]  = '{v, F_DWAIT, 64'd0, 64'd0, 64'd0};
    v = idle; v.mem_load = 1; v.id_redirect = 1;            vecs[9]  = '{v, F_REDIRECT, 64'h8000_0100, 64'd0, 64'd0};
    v = vecs[5].stim; v.wb_exception = 1;                   vecs[10] = '{v, F_EXC, 64'd0, 64'h8000_3000, 64'd2};
    v = idle; v.wb_mret = 1; v.wb_exception = 1;            vecs[11] = '{v, F_EXC, 64'd0, 64'h8000_3000, 64'd2};

    for (int k = 0; k < 12; k++) begin
      do_reset();
      step(vecs[k].stim, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d tbl_flags", k), 64'(last_flags), 64'(vecs[k].flags));
      chk($sformatf("vec%0d tbl_rpc", k), last_rpc, vecs[k].rpc);
      chk($sformatf("vec%0d tbl_tpc", k), last_tpc, vecs[k].tpc);
      chk($sformatf("vec%0d tbl_cause", k), last_tcause, vecs[k].tcause);
    end

    // mret alone redirects to mepc
    do_reset();
    v = idle; v.wb_mret = 1;
    step(v, "mret");
    chk("mret tbl_flags", 64'(last_flags), 64'(F_MRET));
    chk("mret tbl_rpc", last_rpc, 64'h8000_4000);

    // ---- dmem wait 3 cycles, then completes cleanly
    do_reset();
    v = idle; v.mem_load = 1; v.dmem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step(v, $sformatf("dwait%0d", k));
      chk($sformatf("dwait%0d tbl_flags", k), 64'(last_flags), 64'(F_DWAIT));
    end
    v.dmem_ready = 1;
    step(v, "dwait_done");
    chk("dwait_done tbl_flags", 64'(last_flags), 64'(F_NONE));
    step(idle, "dwait_after");

    // ---- store never completes: timeout trap, then trap vector
    do_reset();
    v = idle; v.mem_store = 1; v.dmem_ready = 0;
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      step(v, $sformatf("tmo%0d", k));
      chk($sformatf("tmo%0d tbl_flags", k), 64'(last_flags), 64'(F_DWAIT));
    end
    step(v, "tmo_trap");
    chk("tmo_trap tbl_flags", 64'(last_flags), 64'(F_TIMEOUT));
    chk("tmo_trap tbl_cause", last_tcause, 64'd7);
    chk("tmo_trap tbl_tpc", last_tpc, 64'h8000_2000);
    v = idle; v.wb_exception = 1;
    step(v, "tmo_vec");
    chk("tmo_vec tbl_flags", 64'(last_flags), 64'(F_TRAPST));
    chk("tmo_vec tbl_rpc", last_rpc, 64'h8000_0004);
    step(idle, "tmo_run");
    chk("tmo_run tbl_flags", 64'(last_flags), 64'(F_NONE));

    // ---- MDU busy 4 cycles then ID redirect
    do_reset();
    v = idle; v.ex_mdu_busy = 1;
    for (int k = 0; k < 4; k++) begin
      step(v, $sformatf("mdu%0d", k));
      chk($sformatf("mdu%0d tbl_flags", k), 64'(last_flags), 64'(F_MDU));
    end
    v = idle; v.id_redirect = 1;
    step(v, "mdu_redir");
    chk("mdu_redir tbl_flags", 64'(last_flags), 64'(F_REDIRECT));
    chk("mdu_redir tbl_rpc", last_rpc, 64'h8000_0100);

    // ---- reset asserted mid-DWAIT
    do_reset();
    v = idle; v.mem_load = 1; v.dmem_ready = 0;
    step(v, "rst_dw0");
    step(v, "rst_dw1");
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    model_reset();
    apply(idle);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_release");
    step(idle, "rst_run");

    // ---- randomized traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      v.id_rs1       = 5'($urandom_range(0, 3));
      v.id_rs2       = 5'($urandom_range(0, 3));
      v.id_rs1_used  = 1'($urandom_range(0, 1));
      v.id_rs2_used  = 1'($urandom_range(0, 1));
      v.id_redirect  = 1'($urandom_range(0, 1));
      v.id_target    = {$urandom, $urandom};
      v.ex_load      = 1'($urandom_range(0, 1));
      v.ex_rd        = 5'($urandom_range(0, 3));
      v.ex_mdu_busy  = ($urandom_range(0, 4) == 0);
      v.mem_load     = ($urandom_range(0, 2) == 0);
      v.mem_store    = ($urandom_range(0, 3) == 0);
      v.mem_pc       = {$urandom, $urandom};
      v.dmem_ready   = ($urandom_range(0, 2) != 0);
      v.wb_exception = ($urandom_range(0, 19) == 0);
      v.wb_mret      = ($urandom_range(0, 19) == 0);
      v.wb_pc        = {$urandom, $urandom};
      v.wb_cause     = 64'($urandom_range(0, 15));
      v.mtvec        = {$urandom, $urandom};
      v.mepc         = {$urandom, $urandom};
      step(v, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
